// File: rtl/vga_rect_fill.sv
// ============================================================================
// vga_rect_fill : clipped rectangle-fill / screen-clear plot sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module vga_rect_fill #(
  parameter int         SCREEN_W    = 160,
  parameter int         SCREEN_H    = 120,
  parameter logic [2:0] CLEAR_COLOR = 3'b000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       clear,
  input  logic [7:0] x0,
  input  logic [6:0] y0,
  input  logic [7:0] w,
  input  logic [6:0] h,
  input  logic [2:0] color,
  output logic       busy,
  output logic       done,
  output logic [7:0] VGA_X,
  output logic [6:0] VGA_Y,
  output logic [2:0] VGA_COLOR,
  output logic       plot
);

  localparam logic [8:0] SCR_W9 = 9'(SCREEN_W);
  localparam logic [7:0] SCR_H8 = 8'(SCREEN_H);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_nx;

  logic [7:0] xs;
  logic [6:0] ys;
  logic [8:0] we;
  logic [7:0] he;
  logic [2:0] col;
  logic [8:0] cx;
  logic [7:0] cy;

  logic [8:0] room_x;
  logic [7:0] room_y;
  logic [8:0] clip_w;
  logic [7:0] clip_h;
  logic       degen;
  logic       last_col;
  logic       last_pix;

  // Remaining room is computed one bit wider than the coordinate so x0/y0
  // near the edge cannot wrap; degenerate commands bypass FILL entirely.
  always_comb begin
    room_x   = SCR_W9 - {1'b0, x0};
    room_y   = SCR_H8 - {1'b0, y0};
    clip_w   = ({1'b0, w} < room_x) ? {1'b0, w} : room_x;
    clip_h   = ({1'b0, h} < room_y) ? {1'b0, h} : room_y;
    degen    = ({1'b0, x0} >= SCR_W9) || ({1'b0, y0} >= SCR_H8) ||
               (w == 8'd0) || (h == 7'd0);
    last_col = (cx == we - 9'd1);
    last_pix = last_col && (cy == he - 8'd1);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    done      = 1'b0;
    plot      = 1'b0;
    VGA_X     = 8'({1'b0, xs} + cx);
    VGA_Y     = 7'({1'b0, ys} + cy);
    VGA_COLOR = col;
    case (state)
      IDLE: begin
        if (clear) begin
          state_nx = FILL;
        end else if (start) begin
          state_nx = degen ? DONE : FILL;
        end
      end
      FILL: begin
        busy = 1'b1;
        plot = 1'b1;
        if (last_pix) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Counters freeze on the final pixel so the VGA outputs hold it afterwards.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      xs  <= 8'd0;
      ys  <= 7'd0;
      we  <= 9'd0;
      he  <= 8'd0;
      col <= 3'd0;
      cx  <= 9'd0;
      cy  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            xs  <= 8'd0;
            ys  <= 7'd0;
            we  <= SCR_W9;
            he  <= SCR_H8;
            col <= CLEAR_COLOR;
            cx  <= 9'd0;
            cy  <= 8'd0;
          end else if (start && !degen) begin
            xs  <= x0;
            ys  <= y0;
            we  <= clip_w;
            he  <= clip_h;
            col <= color;
            cx  <= 9'd0;
            cy  <= 8'd0;
          end
        end
        FILL: begin
          if (!last_pix) begin
            if (last_col) begin
              cx <= 9'd0;
              cy <= cy + 8'd1;
            end else begin
              cx <= cx + 9'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_rect_fill.sv
// ============================================================================
// tb_vga_rect_fill : scoreboard bench for vga_rect_fill
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vga_rect_fill;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] x0 = 8'd0;
  logic [6:0] y0 = 7'd0;
  logic [7:0] w = 8'd0;
  logic [6:0] h = 7'd0;
  logic [2:0] color = 3'd0;
  logic       busy, done, plot;
  logic [7:0] VGA_X;
  logic [6:0] VGA_Y;
  logic [2:0] VGA_COLOR;

  int n_cmp = 0;
  int n_err = 0;
  logic [17:0] q[$];

  vga_rect_fill dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .start    (start),
    .clear    (clear),
    .x0       (x0),
    .y0       (y0),
    .w        (w),
    .h        (h),
    .color    (color),
    .busy     (busy),
    .done     (done),
    .VGA_X    (VGA_X),
    .VGA_Y    (VGA_Y),
    .VGA_COLOR(VGA_COLOR),
    .plot     (plot)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_plot"}, 32'(plot), 32'd0);
    check({tag, "_xyc"}, 32'({VGA_X, VGA_Y, VGA_COLOR}), 32'd0);
  endtask

  task automatic randomize_data();
    x0    = 8'($urandom);
    y0    = 7'($urandom);
    w     = 8'($urandom);
    h     = 7'($urandom);
    color = 3'($urandom);
  endtask

  // Push the expected pixel stream, issue the command, then watch n+3 cycles.
  task automatic run_cmd(input string tag, input logic s, input logic c,
                         input logic [7:0] ix0, input logic [6:0] iy0,
                         input logic [7:0] iw, input logic [6:0] ih,
                         input logic [2:0] icol);
    int xi, yi, wi, hi, ew, eh, n;
    int plots, done_k, done_cnt, busy_err, gap_err;
    logic [17:0] e;
    xi = ix0; yi = iy0; wi = iw; hi = ih;
    if (c) begin
      for (int y = 0; y < 120; y++)
        for (int x = 0; x < 160; x++)
          q.push_back({8'(x), 7'(y), 3'b000});
    end else if (s && !(xi >= 160 || yi >= 120 || wi == 0 || hi == 0)) begin
      ew = (wi < 160 - xi) ? wi : 160 - xi;
      eh = (hi < 120 - yi) ? hi : 120 - yi;
      for (int y = 0; y < eh; y++)
        for (int x = 0; x < ew; x++)
          q.push_back({8'(xi + x), 7'(yi + y), icol});
    end
    n = q.size();
    plots = 0; done_k = -1; done_cnt = 0; busy_err = 0; gap_err = 0;

    @(negedge clk);
    start = s; clear = c; x0 = ix0; y0 = iy0; w = iw; h = ih; color = icol;
    @(posedge clk);
    #1;
    start = 1'b0; clear = 1'b0;
    randomize_data();
    for (int k = 1; k <= n + 3; k++) begin
      @(negedge clk);
      if (plot) begin
        plots++;
        if (k != plots) gap_err++;
        if (q.size() != 0) begin
          e = q.pop_front();
          check({tag, "_pixel"}, 32'({VGA_X, VGA_Y, VGA_COLOR}), 32'(e));
        end
      end
      if (done) begin
        done_cnt++;
        done_k = k;
      end
      if (busy != (k <= n + 1)) busy_err++;
    end
    check({tag, "_plots"}, 32'(plots), 32'(n));
    check({tag, "_done_cycle"}, 32'(done_k), 32'(n + 1));
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_gaps"}, 32'(gap_err), 32'd0);
    check({tag, "_busy_window"}, 32'(busy_err), 32'd0);
    check({tag, "_leftover"}, 32'(q.size()), 32'd0);
    q.delete();
  endtask

  initial begin
    int plots, done_seen;
    logic [17:0] e;

    // Power-up reset
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("por");
    @(negedge clk);
    reset = 1'b0;

    run_cmd("rect2x2", 1'b1, 1'b0, 8'd10, 7'd5, 8'd2, 7'd2, 3'b100);
    run_cmd("clip_corner", 1'b1, 1'b0, 8'd158, 7'd118, 8'd4, 7'd4, 3'b010);
    run_cmd("clip_wide", 1'b1, 1'b0, 8'd150, 7'd0, 8'd255, 7'd1, 3'b001);
    run_cmd("clear_prio", 1'b1, 1'b1, 8'd0, 7'd0, 8'd1, 7'd1, 3'b111);
    run_cmd("degen_w0", 1'b1, 1'b0, 8'd5, 7'd5, 8'd0, 7'd3, 3'b011);
    run_cmd("degen_x160", 1'b1, 1'b0, 8'd160, 7'd5, 8'd3, 7'd3, 3'b011);
    run_cmd("degen_y120", 1'b1, 1'b0, 8'd5, 7'd120, 8'd3, 7'd3, 3'b011);
    run_cmd("degen_h0", 1'b1, 1'b0, 8'd5, 7'd5, 8'd3, 7'd0, 3'b011);

    // Mid-sim reset with random inputs, asserted between clock edges
    @(negedge clk);
    randomize_data();
    start = 1'b1;
    x0 = 8'd40; y0 = 7'd40; w = 8'd20; h = 7'd20;
    repeat (4) @(posedge clk);
    #3;
    randomize_data();
    reset = 1'b1;
    #1;
    check_idle_outputs("midreset");
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("midreset_idle_busy", 32'(busy), 32'd0);

    // 10x10 with an ignored restart at plot 3 and reset at plot 50
    for (int y = 0; y < 10; y++)
      for (int x = 0; x < 10; x++)
        q.push_back({8'(20 + x), 7'(30 + y), 3'b101});
    @(negedge clk);
    start = 1'b1; x0 = 8'd20; y0 = 7'd30; w = 8'd10; h = 7'd10; color = 3'b101;
    @(posedge clk);
    #1;
    start = 1'b0;
    randomize_data();
    plots = 0; done_seen = 0;
    for (int k = 1; k <= 60 && plots < 50; k++) begin
      @(negedge clk);
      if (start) start = 1'b0;
      if (done) done_seen++;
      if (plot) begin
        plots++;
        e = q.pop_front();
        check("abort_pixel", 32'({VGA_X, VGA_Y, VGA_COLOR}), 32'(e));
        if (plots == 3) begin
          start = 1'b1; x0 = 8'd0; y0 = 7'd0; w = 8'd3; h = 7'd3; color = 3'b001;
        end
      end
    end
    check("abort_plots_before_reset", 32'(plots), 32'd50);
    #2;
    reset = 1'b1;
    #1;
    check("abort_plot_drop", 32'(plot), 32'd0);
    check("abort_busy_drop", 32'(busy), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    q.delete();
    reset = 1'b0;

    run_cmd("after_abort_1x1", 1'b1, 1'b0, 8'd7, 7'd9, 8'd1, 7'd1, 3'b110);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/vga_rect_fill.md
Name: vga_rect_fill

Overview:
Sequencer for the pixel-plot interface (VGA_X, VGA_Y, VGA_COLOR, plot) on the 160x120, 3-bit-colour frame buffer.
- Accepts a rectangle-fill command or a full-screen clear and emits one plot per clock in raster order.
- Clips every command to the screen.
- Signals completion with busy/done.
- Sits between user logic (switch/key decoders, game FSMs) and the top-level VGA plot outputs.

Parameters:
SCREEN_W, 160, visible columns (VGA_X range 0..SCREEN_W-1)
SCREEN_H, 120, visible rows (VGA_Y range 0..SCREEN_H-1)
CLEAR_COLOR, 3'b000, colour used by the clear command

Ports:
CLOCK_50  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request rectangle fill, sampled in IDLE only
clear  input  1  request full-screen fill with CLEAR_COLOR, sampled in IDLE only
x0  input  8  rectangle left column
y0  input  7  rectangle top row
w  input  8  rectangle width in pixels
h  input  7  rectangle height in pixels
color  input  3  rectangle colour
busy  output  1  high while a command is in progress (FILL or DONE state)
done  output  1  one-cycle pulse on command completion
VGA_X  output  8  pixel column
VGA_Y  output  7  pixel row
VGA_COLOR  output  3  pixel colour
plot  output  1  pixel written on every cycle this is high

Behaviour:
- Reset (async, immediate): state=IDLE; busy=0, done=0, plot=0; VGA_X=0, VGA_Y=0, VGA_COLOR=0.
- States: IDLE, FILL, DONE.

IDLE:
- clear has priority over start when both are high in the same cycle; start is ignored in that case.
- clear: latch xs=0, ys=0, we=SCREEN_W, he=SCREEN_H, col=CLEAR_COLOR.
- start: latch xs=x0, ys=y0, col=color.
  - we=min(w, SCREEN_W-x0); he=min(h, SCREEN_H-y0). Compute in 9-bit/8-bit to avoid wrap.
  - If x0>=SCREEN_W, y0>=SCREEN_H, w==0 or h==0: go to DONE directly with no plots.
- Otherwise go to FILL. Column counter cx=0, row counter cy=0.

FILL:
- One pixel per cycle: plot=1, VGA_X=xs+cx, VGA_Y=ys+cy, VGA_COLOR=col.
- Raster order: cx increments; when cx==we-1, cx=0 and cy increments.
- After the pixel with cx==we-1 and cy==he-1, go to DONE.
- Exactly we*he plot cycles, contiguous, with no gaps.

DONE:
- plot=0, done=1, busy=1 for exactly one cycle, then IDLE.

Timing and other rules:
- Latency: command sampled at edge N; first plot visible in cycle N+1; last plot in cycle N+we*he; done in cycle N+we*he+1; new command accepted from cycle N+we*he+2.
- Degenerate command: done in cycle N+1.
- start/clear while busy are ignored, not queued.
- Inputs x0..color are sampled only at acceptance; later changes have no effect on the running command.
- VGA_X/VGA_Y/VGA_COLOR hold their last values when plot=0; their values are don't-care to consumers.
- Clipped outputs never exceed SCREEN_W-1 / SCREEN_H-1.
- Reset during FILL aborts immediately: plot drops asynchronously and no done pulse is produced.

Test Plan:
1. Assert reset mid-sim with random inputs -> busy=0, done=0, plot=0, VGA_X=0, VGA_Y=0, VGA_COLOR=0 immediately; IDLE after release.
2. start with x0=10, y0=5, w=2, h=2, color=3'b100 -> plots (10,5),(11,5),(10,6),(11,6) colour 4 in cycles N+1..N+4; done=1 at N+5; busy high N+1..N+5.
3. start with x0=158, y0=118, w=4, h=4, color=3'b010 -> exactly 4 plots: (158,118),(159,118),(158,119),(159,119); done at N+5.
4. clear and start (x0=0, w=1, h=1, color=7) both high in the same cycle -> 19200 plots, all colour 0, covering every (x,y) once in raster order; done at N+19201; no colour-7 plot.
5. Degenerate commands: w=0; then x0=160; then y0=120 -> no plot cycles; done at N+1; busy high only in N+1.
6. start of 10x10 rectangle, pulse start again at plot #3 with other params, then assert reset at plot #50 -> second start ignored (first 50 plots match the original rectangle); plot=0 immediately on reset; no done pulse; a new 1x1 command after release plots once.
